// File: rtl/xc_pkg.sv
// xc_pkg: state encodings and timing helpers shared by the XC amplitude/timing stages
package xc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_SHUTDOWN
    } ramp_state_e;

    function automatic int calc_divider(input int clk_frequency, input int step_frequency);
        return clk_frequency / step_frequency;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every DIVIDER clocks
module tick_gen #(
    parameter int DIVIDER = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == LAST;

    always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/amplitude_ramp.sv
// amplitude_ramp: slew-limits the sine stage amplitude toward a loaded target, one LSB per tick
module amplitude_ramp
    import xc_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 10000000,
    parameter int STEP_FREQUENCY = 1000,
    parameter int RESOLUTION     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] target,
    input  logic                  target_load,
    output logic [RESOLUTION-1:0] max_value,
    output logic                  sine_enable,
    output logic                  busy,
    output logic                  done
);

    localparam int DIVIDER = calc_divider(CLK_FREQUENCY, STEP_FREQUENCY);

    if (DIVIDER < 2) begin : g_bad_divider
        $error("amplitude_ramp: CLK_FREQUENCY/STEP_FREQUENCY must be at least 2");
    end

    ramp_state_e           state_q, state_d;
    logic [RESOLUTION-1:0] max_q, max_d, target_q, target_d, step_val;
    logic                  sine_enable_q, sine_enable_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  tick;

    tick_gen #(.DIVIDER(DIVIDER)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        target_d = target_load ? target : target_q;
        step_val = (max_q < target_q) ? max_q + 1'b1 :
                   (max_q > target_q) ? max_q - 1'b1 : max_q;
        state_d  = state_q;
        max_d    = max_q;
        case (state_q)
            ST_IDLE: state_d = enable ? ST_RAMP : ST_IDLE;
            ST_RAMP: begin
                max_d   = (enable && tick) ? step_val : max_q;
                // compare the value about to be registered so done lands with the final step
                state_d = !enable ? ST_SHUTDOWN : (max_d == target_d) ? ST_HOLD : ST_RAMP;
            end
            ST_HOLD: state_d = !enable ? ST_SHUTDOWN :
                               (target_load && target != max_q) ? ST_RAMP : ST_HOLD;
            default: begin
                max_d   = (!enable && tick && max_q != '0) ? max_q - 1'b1 : max_q;
                state_d = enable ? ST_RAMP : (tick && max_q == '0) ? ST_IDLE : ST_SHUTDOWN;
            end
        endcase
        sine_enable_d = state_d != ST_IDLE;
        busy_d        = state_d == ST_RAMP || state_d == ST_SHUTDOWN;
        done_d        = state_q == ST_RAMP && state_d == ST_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            max_q         <= '0;
            target_q      <= '0;
            sine_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_q         <= max_d;
            target_q      <= target_d;
            sine_enable_q <= sine_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign max_value   = max_q;
    assign sine_enable = sine_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
